sw_core: RTL and testbench

SW_CORE -- requirements
Module: sw_core

---
 rtl/sw_core_pkg.sv | 32 +++
 rtl/sw_core_if.sv | 28 ++
 rtl/sw_rr_arb.sv | 55 +++++
 rtl/sw_core.sv | 72 +++++++
 tb/tb_sw_core.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sw_core_pkg.sv
// Shared switch definitions: flit width, port count, port-index type and the
// round-robin search helper used by every output arbiter.
package sw_core_pkg;

  localparam int PKT_W = 36;
  localparam int NPORT = 4;

  typedef logic [1:0] port_idx_t;

  typedef struct packed {
    logic      found;
    port_idx_t idx;
  } rr_pick_t;

  // First asserted requester searching from last+1 upward, wrapping mod NPORT;
  // the last candidate examined is 'last' itself.
  function automatic rr_pick_t rr_pick(input logic [NPORT-1:0] req, input port_idx_t last);
    rr_pick_t  pick;
    port_idx_t cand;
    pick.found = 1'b0;
    pick.idx   = last;
    for (int k = 1; k <= NPORT; k++) begin
      cand = last + port_idx_t'(k);
      if (!pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sw_core_if.sv
// Switch data-plane bundle between four input buffers and the switch core.
//   req0..req3 : request vectors (bit j -> output j), from buffers
//   co0..co3   : head flits, from buffers
//   ack0..ack3 : dequeue grants, to buffers
//   o0..o3     : output port flits, to downstream
// master = buffer/bench side, slave = switch core side.
interface sw_core_if #(parameter int PKT_W = sw_core_pkg::PKT_W);

  logic [sw_core_pkg::NPORT-1:0] req0, req1, req2, req3;
  logic [PKT_W-1:0]              co0, co1, co2, co3;
  logic                          ack0, ack1, ack2, ack3;
  logic [PKT_W-1:0]              o0, o1, o2, o3;

  modport master (
    output req0, req1, req2, req3,
    output co0, co1, co2, co3,
    input  ack0, ack1, ack2, ack3,
    input  o0, o1, o2, o3
  );

  modport slave (
    input  req0, req1, req2, req3,
    input  co0, co1, co2, co3,
    output ack0, ack1, ack2, ack3,
    output o0, o1, o2, o3
  );

endinterface

// File: rtl/sw_rr_arb.sv
// Round-robin arbiter for one switch output with hold-while-requested locking.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   req   : requesters (bit i = input i)
//   grant : one-hot grant, decoded only from busy/owner registers
module sw_rr_arb
  import sw_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  output logic [NPORT-1:0] grant
);

  logic      busy_r, busy_s;
  port_idx_t owner_r, owner_s;
  rr_pick_t  pick_s;

  // Next owner: hold while owner still requests, else rotate to next requester.
  always_comb begin
    pick_s  = rr_pick(req, owner_r);
    busy_s  = busy_r;
    owner_s = owner_r;
    if (busy_r && req[owner_r]) begin
      busy_s  = 1'b1;
      owner_s = owner_r;
    end else if (pick_s.found) begin
      busy_s  = 1'b1;
      owner_s = pick_s.idx;
    end else begin
      busy_s  = 1'b0;
      owner_s = owner_r;
    end
  end

  // Arbiter state; owner resets to 3 so input 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r  <= 1'b0;
      owner_r <= 2'd3;
    end else begin
      busy_r  <= busy_s;
      owner_r <= owner_s;
    end
  end

  // Grant decode from registers only, so it is one-hot by construction.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NPORT; i++) begin
      grant[i] = busy_r && (owner_r == port_idx_t'(i));
    end
  end

endmodule

// File: rtl/sw_core.sv
// 4x4 switch core: one round-robin arbiter per output, ack combine per input
// and a combinational crossbar.
//   clk : clock
//   rst : asynchronous active-low reset (clears grants, hence acks and outputs)
//   bus : sw_core_if slave modport (req/co in, ack/o out)
module sw_core
  import sw_core_pkg::*;
#(
  parameter int PKT_W = sw_core_pkg::PKT_W
) (
  input  logic     clk,
  input  logic     rst,
  sw_core_if.slave bus
);

  logic [NPORT-1:0] req_s   [NPORT];
  logic [PKT_W-1:0] co_s    [NPORT];
  logic [NPORT-1:0] col_s   [NPORT];  // col_s[j][i] = input i requests output j
  logic [NPORT-1:0] grant_s [NPORT];  // grant_s[j][i] = output j granted to input i
  logic [NPORT-1:0] ack_s;
  logic [PKT_W-1:0] o_s     [NPORT];

  assign req_s[0] = bus.req0;
  assign req_s[1] = bus.req1;
  assign req_s[2] = bus.req2;
  assign req_s[3] = bus.req3;
  assign co_s[0]  = bus.co0;
  assign co_s[1]  = bus.co1;
  assign co_s[2]  = bus.co2;
  assign co_s[3]  = bus.co3;

  // Transpose input request vectors into per-output requester columns.
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      for (int i = 0; i < NPORT; i++) begin
        col_s[j][i] = req_s[i][j];
      end
    end
  end

  for (genvar j = 0; j < NPORT; j++) begin : g_arb
    sw_rr_arb u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (col_s[j]),
      .grant (grant_s[j])
    );
  end

  // Ack is the OR over outputs; crossbar ORs masked flits (grant is one-hot,
  // and an ungranted output collapses to zero).
  always_comb begin
    ack_s = '0;
    for (int j = 0; j < NPORT; j++) begin
      o_s[j] = '0;
      for (int i = 0; i < NPORT; i++) begin
        ack_s[i] = ack_s[i] | grant_s[j][i];
        o_s[j]   = o_s[j] | (co_s[i] & {PKT_W{grant_s[j][i]}});
      end
    end
  end

  assign bus.ack0 = ack_s[0];
  assign bus.ack1 = ack_s[1];
  assign bus.ack2 = ack_s[2];
  assign bus.ack3 = ack_s[3];
  assign bus.o0   = o_s[0];
  assign bus.o1   = o_s[1];
  assign bus.o2   = o_s[2];
  assign bus.o3   = o_s[3];

endmodule

// File: tb/tb_sw_core.sv
// Randomized plus directed bench for sw_core against a queue-free reference
// model of per-output round-robin arbitration with hold.
module tb_sw_core;
  localparam int W = 36;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_core_if #(.PKT_W(W)) bus ();
  sw_core #(.PKT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0]   req [4];
  logic [W-1:0] co  [4];
  assign bus.req0 = req[0];
  assign bus.req1 = req[1];
  assign bus.req2 = req[2];
  assign bus.req3 = req[3];
  assign bus.co0  = co[0];
  assign bus.co1  = co[1];
  assign bus.co2  = co[2];
  assign bus.co3  = co[3];

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: per output, busy flag and owning input.
  int m_busy  [4];
  int m_owner [4];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < 4; j++) begin
      m_busy[j]  = 0;
      m_owner[j] = 3;
    end
  endfunction

  // One rising edge of every arbiter, applied to the currently driven requests.
  function automatic void model_edge();
    for (int j = 0; j < 4; j++) begin
      if (!(m_busy[j] != 0 && req[m_owner[j]][j] == 1'b1)) begin
        int found = 0;
        for (int k = 1; k <= 4; k++) begin
          int c = (m_owner[j] + k) % 4;
          if (found == 0 && req[c][j] == 1'b1) begin
            m_owner[j] = c;
            found = 1;
          end
        end
        m_busy[j] = found;
      end
    end
  endfunction

  function automatic logic [3:0] dut_ack();
    return {bus.ack3, bus.ack2, bus.ack1, bus.ack0};
  endfunction

  function automatic logic [W-1:0] dut_o(input int j);
    case (j)
      0: return bus.o0;
      1: return bus.o1;
      2: return bus.o2;
      default: return bus.o3;
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [3:0]   e_ack;
    logic [W-1:0] e_o;
    e_ack = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if (m_busy[j] != 0) e_ack[m_owner[j]] = 1'b1;
    end
    check_val({tag, "_ack"}, 64'(dut_ack()), 64'(e_ack));
    for (int j = 0; j < 4; j++) begin
      e_o = (m_busy[j] != 0) ? co[m_owner[j]] : '0;
      check_val($sformatf("%s_o%0d", tag, j), 64'(dut_o(j)), 64'(e_o));
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_reqs(input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [3:0] r3);
    req[0] = r0; req[1] = r1; req[2] = r2; req[3] = r3;
  endtask

  initial begin
    // Reset with arbitrary requests asserted.
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      req[i] = 4'($urandom());
      co[i]  = W'({$urandom(), $urandom()});
    end
    #3;
    check_val("rst_ack", 64'(dut_ack()), 64'h0);
    for (int j = 0; j < 4; j++) check_val($sformatf("rst_o%0d", j), 64'(dut_o(j)), 64'h0);
    @(posedge clk); #1;
    check_val("rst_hold_ack", 64'(dut_ack()), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // First grant after reset.
    set_reqs(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    co[0] = 36'h0_A5A5_A5A5;
    tick("first");
    check_val("first_ack0", 64'(bus.ack0), 64'h1);
    check_val("first_o0", 64'(bus.o0), 64'h0_A5A5_A5A5);

    // Contention on output 1, released one at a time.
    set_reqs(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick("idle");
    for (int i = 0; i < 4; i++) co[i] = W'(36'h100 + i);
    set_reqs(4'b0010, 4'b0010, 4'b0010, 4'b0010);
    tick("cont0");
    check_val("cont_g0", 64'(dut_ack()), 64'h1);
    tick("cont0h");
    check_val("cont_g0_hold", 64'(dut_ack()), 64'h1);
    for (int i = 0; i < 3; i++) begin
      req[i] = 4'b0000;
      tick("cont");
      check_val($sformatf("cont_g%0d", i + 1), 64'(dut_ack()), 64'(4'b0001 << (i + 1)));
      check_val($sformatf("cont_o1_%0d", i + 1), 64'(bus.o1), 64'(36'h100 + i + 1));
    end

    // Parallel paths.
    set_reqs(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick("idle2");
    set_reqs(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    tick("par");
    check_val("par_ack", 64'(dut_ack()), 64'hF);
    check_val("par_o2", 64'(bus.o2), 64'(co[2]));

    // Hold/lock: input 2 holds output 3 while input 0 waits.
    set_reqs(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick("idle3");
    req[2] = 4'b1000;
    tick("lock");
    req[0] = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      tick("lockh");
      check_val("lock_ack", 64'(dut_ack()), 64'h4);
    end
    check_val("idle_o0", 64'(bus.o0), 64'h0);
    req[2] = 4'b0000;
    tick("lockrel");
    check_val("lockrel_ack", 64'(dut_ack()), 64'h1);

    // Reset mid-grant drops ack immediately.
    rst = 1'b0;
    model_reset();
    #1;
    check_val("midrst_ack", 64'(dut_ack()), 64'h0);
    check_val("midrst_o3", 64'(bus.o3), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with sticky requests so holds happen.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        int r = $urandom_range(0, 9);
        if (r >= 4 && r < 8) begin
          int p = $urandom_range(0, 4);
          req[i] = (p == 4) ? 4'b0000 : (4'b0001 << p);
        end else if (r >= 8) begin
          req[i] = 4'($urandom());
        end else begin
          req[i] = req[i];
        end
        co[i] = W'({$urandom(), $urandom()});
      end
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
